// File: rtl/definition.sv
// rtl/definition.sv - shared widths, FSM encoding and helpers for the attention-bias path
package definition;

  localparam int att_width = 8;
  localparam int BIAS_RES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bias_fsm_t;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/attn_bias_table.sv
// rtl/attn_bias_table.sv - 4-head bias register file, one write port, one registered 4-wide read
module attn_bias_table
  import definition::*;
#(
  parameter int RES = BIAS_RES,
  localparam int AW = $clog2(RES * RES)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_we,
  input  logic [1:0]             i_wr_head,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [att_width-1:0]   i_wr_data,
  input  logic                   i_rd_en,
  input  logic                   i_rd_valid,
  input  logic [AW-1:0]          i_rd_addr,
  output logic [4*att_width-1:0] o_rd_data
);

  logic [att_width-1:0]   r_mem [4][RES*RES];
  logic [4*att_width-1:0] r_rd_data;

  // Contents deliberately survive reset so a loaded table outlives aborted runs.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_head][i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      for (int h = 0; h < 4; h++) begin
        r_rd_data[h*att_width +: att_width] <= i_rd_valid ? r_mem[h][i_rd_addr] : '0;
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/attn_bias_gen.sv
// rtl/attn_bias_gen.sv - walks all (query,key) token pairs and streams the four per-head LeViT biases
module attn_bias_gen
  import definition::*;
#(
  parameter int RES = BIAS_RES,
  localparam int AW = $clog2(RES * RES)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic                        start,
  input  logic                        tbl_we,
  input  logic [1:0]                  tbl_head,
  input  logic [AW-1:0]               tbl_addr,
  input  logic signed [att_width-1:0] tbl_data,
  output logic signed [att_width-1:0] bias_1,
  output logic signed [att_width-1:0] bias_2,
  output logic signed [att_width-1:0] bias_3,
  output logic signed [att_width-1:0] bias_4,
  output logic                        bias_valid,
  output logic [AW-1:0]               q_idx,
  output logic [AW-1:0]               k_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int CW = $clog2(RES);
  localparam logic [CW-1:0] MAXC = CW'(RES - 1);

  bias_fsm_t r_state, w_state_next;
  logic      w_accept, w_issue, w_last;

  logic [CW-1:0] r_kx, r_ky, r_qx, r_qy;
  logic [CW-1:0] w_dx, w_dy;
  logic [AW-1:0] w_addr, w_q, w_k;

  logic          r_s1_valid, r_s1_last;
  logic [AW-1:0] r_s1_addr, r_s1_q, r_s1_k;

  logic          r_valid, r_done;
  logic [AW-1:0] r_q, r_k;

  logic [4*att_width-1:0] w_rd_data;

  assign w_last   = (r_kx == MAXC) && (r_ky == MAXC) && (r_qx == MAXC) && (r_qy == MAXC);
  assign w_accept = (r_state == IDLE) && en && start;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DRAIN waits for done to be presented, so busy drops one edge after done.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && start) w_state_next = RUN;
      end
      RUN: begin
        if (en) begin
          w_issue = 1'b1;
          if (w_last) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (en && r_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || w_accept) begin
      r_kx <= '0;
      r_ky <= '0;
      r_qx <= '0;
      r_qy <= '0;
    end else if (w_issue) begin
      if (r_kx != MAXC) begin
        r_kx <= r_kx + CW'(1);
      end else begin
        r_kx <= '0;
        if (r_ky != MAXC) begin
          r_ky <= r_ky + CW'(1);
        end else begin
          r_ky <= '0;
          if (r_qx != MAXC) begin
            r_qx <= r_qx + CW'(1);
          end else begin
            r_qx <= '0;
            r_qy <= (r_qy == MAXC) ? '0 : r_qy + CW'(1);
          end
        end
      end
    end
  end

  assign w_dx   = CW'(abs_diff(32'(r_qx), 32'(r_kx)));
  assign w_dy   = CW'(abs_diff(32'(r_qy), 32'(r_ky)));
  assign w_addr = AW'(32'(w_dy) * RES + 32'(w_dx));
  assign w_q    = AW'(32'(r_qy) * RES + 32'(r_qx));
  assign w_k    = AW'(32'(r_ky) * RES + 32'(r_kx));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_q     <= '0;
      r_s1_k     <= '0;
    end else if (en) begin
      r_s1_valid <= w_issue;
      r_s1_last  <= w_issue && w_last;
      r_s1_addr  <= w_addr;
      r_s1_q     <= w_q;
      r_s1_k     <= w_k;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_k     <= '0;
    end else if (en) begin
      r_valid <= r_s1_valid;
      r_done  <= r_s1_valid && r_s1_last;
      r_q     <= r_s1_valid ? r_s1_q : '0;
      r_k     <= r_s1_valid ? r_s1_k : '0;
    end
  end

  attn_bias_table #(.RES(RES)) u_table (
    .clk        (clk),
    .rstn       (rstn),
    .i_we       (tbl_we && (r_state == IDLE)),
    .i_wr_head  (tbl_head),
    .i_wr_addr  (tbl_addr),
    .i_wr_data  (tbl_data),
    .i_rd_en    (en),
    .i_rd_valid (r_s1_valid),
    .i_rd_addr  (r_s1_addr),
    .o_rd_data  (w_rd_data)
  );

  assign bias_1     = w_rd_data[0*att_width +: att_width];
  assign bias_2     = w_rd_data[1*att_width +: att_width];
  assign bias_3     = w_rd_data[2*att_width +: att_width];
  assign bias_4     = w_rd_data[3*att_width +: att_width];
  assign bias_valid = r_valid;
  assign done       = r_done;
  assign q_idx      = r_q;
  assign k_idx      = r_k;
  assign busy       = (r_state != IDLE);

endmodule
